// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; MULDIV_FAST_MUL_EN selects single-cycle multiply
module ex_muldiv #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] rsValue,
  input  logic [DATA_WIDTH-1:0] rtValue,
  input  logic                  mthi,
  input  logic                  mtlo,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hiOut,
  output logic [DATA_WIDTH-1:0] loOut
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [2*W-1:0]   acc;       // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [W-1:0]     operand;   // multiplicand magnitude or divisor magnitude
  logic [W-1:0]     rsRaw;     // original dividend, returned as HI on divide by zero
  logic [CNT_W-1:0] cnt;
  logic             isDiv;
  logic             negRes;    // product / quotient sign
  logic             negRem;    // remainder follows the dividend sign
  logic             divZero;

  logic             rsNeg, rtNeg;
  logic [W-1:0]     rsMag, rtMag;
  logic [W:0]       mulSum, divDiff;
  logic [2*W-1:0]   mulNext, divNext, prodFix;
  logic [W-1:0]     quoFix, remFix;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0]   fullProduct;
`endif

  assign busy = (state != IDLE);

  // operand magnitudes, one iteration step of each algorithm, and final sign correction
  always_comb begin
    rsNeg   = ~op[0] & rsValue[W-1];
    rtNeg   = ~op[0] & rtValue[W-1];
    rsMag   = rsNeg ? (W'(0) - rsValue) : rsValue;
    rtMag   = rtNeg ? (W'(0) - rtValue) : rtValue;
    mulSum  = {1'b0, acc[2*W-1:W]} + {1'b0, operand};
    mulNext = acc[0] ? {mulSum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};
    divDiff = acc[2*W-1:W-1] - {1'b0, operand};
    divNext = divDiff[W] ? {acc[2*W-2:0], 1'b0}
                         : {divDiff[W-1:0], acc[W-2:0], 1'b1};
    prodFix = negRes ? ((2*W)'(0) - acc) : acc;
    quoFix  = negRes ? (W'(0) - acc[W-1:0]) : acc[W-1:0];
    remFix  = negRem ? (W'(0) - acc[2*W-1:W]) : acc[2*W-1:W];
`ifdef MULDIV_FAST_MUL_EN
    fullProduct = {{W{1'b0}}, rsMag} * {{W{1'b0}}, rtMag};
`endif
  end

  // control FSM, datapath registers and the architectural HI/LO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      acc     <= '0;
      operand <= '0;
      rsRaw   <= '0;
      cnt     <= '0;
      isDiv   <= 1'b0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
      done    <= 1'b0;
      hiOut   <= '0;
      loOut   <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              isDiv   <= op[1];
              negRes  <= rsNeg ^ rtNeg;
              negRem  <= rsNeg;
              divZero <= op[1] & (rtValue == '0);
              rsRaw   <= rsValue;
              cnt     <= '0;
              acc     <= op[1] ? {{W{1'b0}}, rsMag} : {{W{1'b0}}, rtMag};
              operand <= op[1] ? rtMag : rsMag;
              state   <= RUN;
`ifdef MULDIV_FAST_MUL_EN
              if (!op[1]) begin
                acc   <= fullProduct;
                state <= FIX;
              end
`endif
            end else begin
              if (mthi) hiOut <= rsValue;
              if (mtlo) loOut <= rsValue;
            end
          end
          RUN: begin
            acc <= isDiv ? divNext : mulNext;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(W - 1)) state <= FIX;
          end
          FIX: begin
            if (!isDiv) begin
              {hiOut, loOut} <= prodFix;
            end else if (divZero) begin
              hiOut <= rsRaw;
              loOut <= '1;
            end else begin
              hiOut <= remFix;
              loOut <= quoFix;
            end
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - table-driven scoreboard bench for ex_muldiv
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rsValue;
  logic [31:0] rtValue;
  logic        mthi;
  logic        mtlo;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hiOut;
  logic [31:0] loOut;

  int compared   = 0;
  int mismatched = 0;

  logic [63:0] sbQ[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[14];

  ex_muldiv #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rsValue(rsValue),
    .rtValue(rtValue), .mthi(mthi), .mtlo(mtlo), .flush(flush),
    .busy(busy), .done(done), .hiOut(hiOut), .loOut(loOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] rs, input logic [31:0] rt);
    longint p;
    int     q, r;
    case (o)
      2'b00: begin
        p = longint'($signed(rs)) * longint'($signed(rt));
        return p;
      end
      2'b01: return {32'b0, rs} * {32'b0, rt};
      2'b10: begin
        if (rt == 0) return {rs, 32'hFFFF_FFFF};
        if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(rs) / $signed(rt);
        r = $signed(rs) % $signed(rt);
        return {r, q};
      end
      default: begin
        if (rt == 0) return {rs, 32'hFFFF_FFFF};
        return {rs % rt, rs / rt};
      end
    endcase
  endfunction

  function automatic int expBusy(input logic [1:0] o);
`ifdef MULDIV_FAST_MUL_EN
    if (!o[1]) return 1;
`endif
    return 33;
  endfunction

  // scoreboard: every done pops one expected {HI, LO}
  always @(negedge clk) begin
    if (rst && done) begin
      if (sbQ.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = sbQ.pop_front();
        check("result_hilo", {hiOut, loOut}, e);
      end
    end
  end

  // launches one op at the current negedge; optional start+mtlo, optional start+mthi injection while busy
  task automatic runOp(input logic [1:0] o, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [63:0] exp, input bit withMtlo, input int injectAt);
    int          cyc = 0;
    int          busyCyc = 0;
    bit          seen = 0;
    logic [31:0] prevHi, prevLo;
    prevHi  = hiOut;
    prevLo  = loOut;
    sbQ.push_back(exp);
    op      = o;
    rsValue = rs;
    rtValue = rt;
    start   = 1'b1;
    mtlo    = withMtlo;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        mtlo  = 1'b0;
        if (withMtlo) check("mtlo_with_start_dropped", loOut, prevLo);
      end
      if (injectAt != 0 && cyc == injectAt + 1) begin
        start = 1'b0;
        mthi  = 1'b0;
        check("mthi_while_busy_dropped", hiOut, prevHi);
      end
      if (busy) busyCyc++;
      if (done) begin
        seen = 1;
        check("busy_low_at_done", busy, 1'b0);
      end
      if (injectAt != 0 && cyc == injectAt) begin
        start   = 1'b1;
        mthi    = 1'b1;
        op      = 2'b01;
        rsValue = 32'hDEAD_BEEF;
      end
    end
    check("done_seen", seen, 1'b1);
    check("busy_cycles", busyCyc, expBusy(o));
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("scoreboard_drained", sbQ.size(), 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op = '0; rsValue = '0; rtValue = '0;
    mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;

    vecs[0] = '{2'b00, 32'hFFFF_FFFE, 32'h3,          32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'b11, 32'd100,       32'h0,          32'd100,       32'hFFFF_FFFF};
    vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0,         32'h8000_0000};
    vecs[5] = '{2'b10, 32'hFFFF_FFFB, 32'h0,          32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[6] = '{2'b10, 32'd7,         32'hFFFF_FFFE,  32'h1,         32'hFFFF_FFFD};
    vecs[7] = '{2'b00, 32'h7FFF_FFFF, 32'h8000_0000,  32'hC000_0000, 32'h8000_0000};
    vecs[8] = '{2'b11, 32'hFFFF_FFFF, 32'd10,         32'd5,         32'h1999_9999};
    vecs[9] = '{2'b01, 32'h0,         32'h1234_5678,  32'h0,         32'h0};
    for (int i = 10; i < 14; i++) begin
      logic [63:0] m;
      vecs[i].op = 2'($urandom_range(0, 3));
      vecs[i].rs = $urandom;
      vecs[i].rt = (i == 12) ? 32'($urandom_range(1, 9)) : $urandom;
      m = refModel(vecs[i].op, vecs[i].rs, vecs[i].rt);
      vecs[i].hi = m[63:32];
      vecs[i].lo = m[31:0];
    end

    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_hilo", {hiOut, loOut}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++)
      runOp(vecs[i].op, vecs[i].rs, vecs[i].rt, {vecs[i].hi, vecs[i].lo}, 1'b0, 0);

    // MTHI / MTLO preload
    rsValue = 32'h11; mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0; rsValue = 32'h22; mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0;
    check("mthi_mtlo_write", {hiOut, loOut}, {32'h11, 32'h22});

    // flush at E10 of a DIVU
    op = 2'b11; rsValue = 32'd1000; rtValue = 32'd3; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 9) flush = 1'b1;
    end
    flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    check("flush_hilo_kept", {hiOut, loOut}, {32'h11, 32'h22});
    runOp(2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 0);

    // start+mthi while busy, then start+mtlo in idle
    runOp(2'b11, 32'd50, 32'd5, {32'd0, 32'd10}, 1'b0, 12);
    runOp(2'b10, 32'hFFFF_FF9C, 32'd10, {32'h0, 32'hFFFF_FFF6}, 1'b1, 0);

    // asynchronous reset mid-operation
    op = 2'b00; rsValue = 32'h1234; rtValue = 32'h5678; start = 1'b1;
    sbQ.push_back(64'h0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    sbQ.delete();
    check("midrun_reset_busy", busy, 1'b0);
    check("midrun_reset_hilo", {hiOut, loOut}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("post_reset_hilo", {hiOut, loOut}, 64'h0);
    check("post_reset_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
